int_seq_ctrl: RTL and testbench

INT_SEQ_CTRL -- requirements
Module: int_seq_ctrl

---
 rtl/int_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_int_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/int_seq_ctrl.sv
// rtl/int_seq_ctrl.sv - interrupt entry/return sequencer driving PC/CCR stack pushes and pops
module int_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_in,
    input  logic        rti,
    input  logic        mem_busy,
    input  logic [31:0] pc_fetch,
    output logic        stall_fetch,
    output logic        flush,
    output logic        pushPc,
    output logic        popPc,
    output logic        pushCCR,
    output logic        popCCR,
    output logic        int1,
    output logic        int2,
    output logic [31:0] pcBeforeInterrupt,
    output logic        load_vector,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        FLUSH = 4'd1,
        INT1  = 4'd2,
        INT2  = 4'd3,
        PCCR  = 4'd4,
        VECT  = 4'd5,
        RCCR  = 4'd6,
        RPC1  = 4'd7,
        RPC2  = 4'd8
    } state_t;

    state_t state;
    logic   pending;
    logic   int_d;
    logic   armed;
    logic   int_edge;
    logic   enter;

    // armed stays low for the first clock after reset so a level already high
    // at release is absorbed into int_d instead of being seen as a new edge
    assign int_edge = int_in & ~int_d & armed;

    // leaving IDLE toward FLUSH consumes the pending request; rti takes priority
    assign enter = (state == IDLE) && !rti && pending;

    // edge detector and single-bit pending request; extra edges simply merge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_d   <= 1'b0;
            armed   <= 1'b0;
            pending <= 1'b0;
        end else begin
            int_d <= int_in;
            armed <= 1'b1;
            if (enter) begin
                pending <= 1'b0;
            end else if (int_edge) begin
                pending <= 1'b1;
            end
        end
    end

    // PC of the first unissued instruction, captured as service begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcBeforeInterrupt <= 32'd0;
        end else if (enter) begin
            pcBeforeInterrupt <= pc_fetch;
        end
    end

    // sequencer: stack-op states wait for the memory stage to release the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rti) begin
                        state <= RCCR;
                    end else if (pending) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: state <= INT1;
                INT1:  if (!mem_busy) state <= INT2;
                INT2:  if (!mem_busy) state <= PCCR;
                PCCR:  if (!mem_busy) state <= VECT;
                VECT:  state <= IDLE;
                RCCR:  if (!mem_busy) state <= RPC1;
                RPC1:  if (!mem_busy) state <= RPC2;
                RPC2:  if (!mem_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // state decode; stack strobes are masked while memory owns the port
    always_comb begin
        stall_fetch = 1'b0;
        flush       = 1'b0;
        pushPc      = 1'b0;
        popPc       = 1'b0;
        pushCCR     = 1'b0;
        popCCR      = 1'b0;
        int1        = 1'b0;
        int2        = 1'b0;
        load_vector = 1'b0;
        busy        = (state != IDLE);
        case (state)
            FLUSH: begin
                flush       = 1'b1;
                stall_fetch = 1'b1;
            end
            INT1: begin
                pushPc      = !mem_busy;
                int1        = 1'b1;
                stall_fetch = 1'b1;
            end
            INT2: begin
                pushPc      = !mem_busy;
                int2        = 1'b1;
                stall_fetch = 1'b1;
            end
            PCCR: begin
                pushCCR     = !mem_busy;
                stall_fetch = 1'b1;
            end
            VECT: begin
                load_vector = 1'b1;
            end
            RCCR: begin
                popCCR      = !mem_busy;
                stall_fetch = 1'b1;
            end
            RPC1: begin
                popPc       = !mem_busy;
                int1        = 1'b1;
                stall_fetch = 1'b1;
            end
            RPC2: begin
                popPc       = !mem_busy;
                int2        = 1'b1;
                stall_fetch = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_int_seq_ctrl.sv
// tb/tb_int_seq_ctrl.sv - randomized and directed bench for int_seq_ctrl against a step-table model
module tb_int_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_in;
    logic        rti;
    logic        mem_busy;
    logic [31:0] pc_fetch;
    logic        stall_fetch, flush, pushPc, popPc, pushCCR, popCCR;
    logic        int1, int2, load_vector, busy;
    logic [31:0] pcBeforeInterrupt;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 idle, 1 entry, 2 return; step indexes the operation list
    int          m_mode;
    int          m_step;
    bit          m_pend;
    bit          m_prev;
    bit          m_armed;
    logic [31:0] m_pcb;

    always #5 clk = ~clk;

    int_seq_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .int_in            (int_in),
        .rti               (rti),
        .mem_busy          (mem_busy),
        .pc_fetch          (pc_fetch),
        .stall_fetch       (stall_fetch),
        .flush             (flush),
        .pushPc            (pushPc),
        .popPc             (popPc),
        .pushCCR           (pushCCR),
        .popCCR            (popCCR),
        .int1              (int1),
        .int2              (int2),
        .pcBeforeInterrupt (pcBeforeInterrupt),
        .load_vector       (load_vector),
        .busy              (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_step  = 0;
        m_pend  = 1'b0;
        m_prev  = 1'b0;
        m_armed = 1'b0;
        m_pcb   = 32'd0;
    endtask

    // one clock: drive at negedge, compare outputs, then advance model past posedge
    task automatic step_cycle(input bit i_int, input bit i_rti, input bit i_mb, input logic [31:0] i_pc);
        bit e_stall, e_flush, e_pushpc, e_poppc, e_pushccr, e_popccr, e_i1, e_i2, e_lv, e_busy;
        bit waits, edge_seen;
        int len;
        @(negedge clk);
        int_in   = i_int;
        rti      = i_rti;
        mem_busy = i_mb;
        pc_fetch = i_pc;
        #1;
        {e_stall, e_flush, e_pushpc, e_poppc, e_pushccr, e_popccr, e_i1, e_i2, e_lv} = '0;
        e_busy = (m_mode != 0);
        if (m_mode == 1) begin
            case (m_step)
                0: begin e_flush = 1; e_stall = 1; end
                1: begin e_pushpc = !i_mb; e_i1 = 1; e_stall = 1; end
                2: begin e_pushpc = !i_mb; e_i2 = 1; e_stall = 1; end
                3: begin e_pushccr = !i_mb; e_stall = 1; end
                default: e_lv = 1;
            endcase
        end else if (m_mode == 2) begin
            case (m_step)
                0: begin e_popccr = !i_mb; e_stall = 1; end
                1: begin e_poppc = !i_mb; e_i1 = 1; e_stall = 1; end
                default: begin e_poppc = !i_mb; e_i2 = 1; e_stall = 1; end
            endcase
        end
        check("stall_fetch", stall_fetch, e_stall);
        check("flush", flush, e_flush);
        check("pushPc", pushPc, e_pushpc);
        check("popPc", popPc, e_poppc);
        check("pushCCR", pushCCR, e_pushccr);
        check("popCCR", popCCR, e_popccr);
        check("int1", int1, e_i1);
        check("int2", int2, e_i2);
        check("load_vector", load_vector, e_lv);
        check("busy", busy, e_busy);
        check("pcBeforeInterrupt", pcBeforeInterrupt, m_pcb);
        check("one_stack_op", 32'(pushPc + popPc + pushCCR + popCCR) <= 1, 1);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            edge_seen = i_int && !m_prev && m_armed;
            m_prev  = i_int;
            m_armed = 1'b1;
            if (m_mode == 0) begin
                if (i_rti) begin
                    m_mode = 2;
                    m_step = 0;
                    if (edge_seen) m_pend = 1'b1;
                end else if (m_pend) begin
                    m_mode = 1;
                    m_step = 0;
                    m_pcb  = i_pc;
                    m_pend = 1'b0;
                end else if (edge_seen) begin
                    m_pend = 1'b1;
                end
            end else begin
                if (edge_seen) m_pend = 1'b1;
                len   = (m_mode == 1) ? 5 : 3;
                waits = (m_mode == 2) || (m_step >= 1 && m_step <= 3);
                if (!waits || !i_mb) begin
                    m_step++;
                    if (m_step == len) begin
                        m_mode = 0;
                        m_step = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {stall_fetch, flush, pushPc, popPc, pushCCR, popCCR, int1, int2, load_vector, busy}, 0);
        check({tag, "_pcb"}, pcBeforeInterrupt, 0);
    endtask

    int pushpc_cnt;
    bit r_int;

    initial begin
        rst_n    = 1'b0;
        int_in   = 1'b0;
        rti      = 1'b0;
        mem_busy = 1'b0;
        pc_fetch = 32'd0;
        model_reset();
        #2;
        check_all_zero("reset_state");
        for (int i = 0; i < 3; i++) step_cycle(0, 0, 0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step_cycle(0, 0, 0, 32'h0);

        // basic entry with pc capture
        for (int i = 0; i < 9; i++) step_cycle(1, 0, 0, 32'h0000_0124);
        check("req021_pcb", pcBeforeInterrupt, 32'h0000_0124);
        step_cycle(0, 0, 0, 32'h0);

        // memory stall held for three cycles in INT2
        pushpc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step_cycle(i >= 0, 0, (i >= 4 && i <= 6), 32'h0000_0300);
            if (i >= 4 && i <= 7) pushpc_cnt += (int2 && pushPc) ? 1 : 0;
        end
        step_cycle(0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step_cycle(0, 0, 0, 32'h0);

        // return sequence
        step_cycle(0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) step_cycle(0, 0, 0, 32'h0);

        // rti and pending together: return first, then entry with later pc
        step_cycle(1, 0, 0, 32'h0000_0400);
        step_cycle(1, 1, 0, 32'h0000_0404);
        for (int i = 0; i < 10; i++) step_cycle(1, 0, 0, 32'h0000_0500 + 32'(i));
        step_cycle(0, 0, 0, 32'h0);

        // three pulses during one entry sequence
        for (int i = 0; i < 18; i++) step_cycle((i % 2) == 0 && i < 6, 0, 0, 32'h0000_0600);
        step_cycle(0, 0, 0, 32'h0);

        // reset during PCCR with int_in held high through release
        step_cycle(1, 0, 0, 32'h0000_0700);
        for (int i = 0; i < 4; i++) step_cycle(1, 0, 0, 32'h0000_0700);
        check("pre_reset_pushCCR", pushCCR, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        for (int i = 0; i < 2; i++) step_cycle(1, 0, 0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step_cycle(1, 0, 0, 32'h0000_0800);

        // randomized traffic
        r_int = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) r_int = ~r_int;
            step_cycle(r_int, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
